// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Receive-side serial PHY for the peripheral UART. It feeds the RX FIFO write port.
// The block synchronises rxd and checks each start bit at mid-bit. It then samples
// DATA_BITS data bits LSB-first and checks 1 or 2 stop bits. Each good byte is
// presented on a valid/ready handshake.
//
// Ports:
//   clock     system clock
//   reset     asynchronous, active-low reset
//   rxd       serial line, idle high, asynchronous to clock
//   div       bit period = div+1 clocks (values below 3 act as 3)
//   rxen      receiver enable; 0 aborts any frame in progress without error
//   nstop     0: one stop bit, 1: two stop bits
//   rx_data   received byte, stable while rx_valid=1
//   rx_valid  byte available
//   rx_ready  consumer accepts the byte
//   frame_err one-cycle pulse: a stop bit was sampled 0
//   overrun   one-cycle pulse: a byte completed while the previous one was unread
//   busy      FSM not in Idle
//   state_db  encoded FSM state (0 Idle, 1 Start, 2 Data, 3 Stop1, 4 Stop2, 5 Break)
//
// Handshake: a byte transfers on every clock edge where rx_valid & rx_ready = 1.
// rx_valid never drops without that transfer. rx_data does not change while
// rx_valid=1, except when a new byte loads on the same edge as a transfer.
//
// Build option: define UART_RX_MAJORITY_VOTE_EN to sample each bit as the
// majority of the last three synchronised line values. With it undefined, the raw
// synchronised value is used.
module uart_rx_deserializer #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic [15:0]          div,
  input  logic                 rxen,
  input  logic                 nstop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           state_db
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP1 = 3'd3,
    S_STOP2 = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
  logic                 rx_bit;
  logic [15:0]          d_eff;
  logic [15:0]          half_d;
  logic [15:0]          cnt;
  logic                 cnt_clr;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 emit_q;
  logic                 shift_en;
  logic                 idx_clr;
  logic                 accept;
  logic                 ferr_nx;

  // The synchroniser resets to 1s, so the line looks idle coming out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The two older line values plus the current rx_s form a three-value window.
  // A lone one-cycle glitch at a sample point is outvoted.
  logic [1:0] hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign rx_bit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_bit = rx_s;
`endif

  assign d_eff  = (div < 16'd3) ? 16'd3 : div;
  assign half_d = {1'b0, d_eff[15:1]};

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    accept   = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        // The start edge uses raw rx_s even when voting is enabled.
        if (!rx_s) state_nx = S_START;
      end
      S_START: begin
        if (cnt == half_d) begin
          if (!rx_bit) begin
            state_nx = S_DATA;
            idx_clr  = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == d_eff) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) state_nx = S_STOP1;
        end
      end
      S_STOP1: begin
        if (cnt == d_eff) begin
          if (!rx_bit) begin
            ferr_nx  = 1'b1;
            state_nx = S_BREAK;
          end else if (nstop) begin
            state_nx = S_STOP2;
          end else begin
            accept   = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (cnt == d_eff) begin
          if (!rx_bit) begin
            ferr_nx  = 1'b1;
            state_nx = S_BREAK;
          end else begin
            accept   = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // A line held low must return high before the next start is allowed.
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // A disabled receiver drops any partial frame without reporting an error.
    if (!rxen) begin
      state_nx = S_IDLE;
      shift_en = 1'b0;
      idx_clr  = 1'b0;
      accept   = 1'b0;
      ferr_nx  = 1'b0;
    end
  end

  // Each data sample also restarts the count, so every bit lasts D+1 cycles.
  assign cnt_clr = (state_nx != state) || shift_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '1;
      emit_q    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_clr ? 16'd0 : cnt + 16'd1;
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en) shreg <= {rx_bit, shreg[DATA_BITS-1:1]};
      // The emit happens one cycle after the accepting stop sample.
      emit_q    <= accept;
      frame_err <= ferr_nx;
      overrun   <= emit_q & rx_valid & ~rx_ready;
      if (emit_q && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign state_db = state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
  localparam int W = 8;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          rxd      = 1'b1;
  logic [15:0]   div      = 16'd9;
  logic          rxen     = 1'b0;
  logic          nstop    = 1'b0;
  logic          rx_ready = 1'b1;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [2:0]    state_db;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_seen = 0, fe_exp = 0;
  int ov_seen = 0, ov_exp = 0;
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  logic         prev_valid = 1'b0;

  uart_rx_deserializer #(.DATA_BITS(W), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .rxd(rxd), .div(div), .rxen(rxen),
    .nstop(nstop), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy), .state_db(state_db)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: a clean frame yields the byte sent. A frame whose data bits carry a
  // one-cycle high glitch exactly at mid-bit reads all ones on a raw sampler and
  // the true bits on a voting sampler.
  function automatic logic [W-1:0] model_byte(input logic [W-1:0] b, input bit glitch);
    logic [W-1:0] r;
    r = b;
`ifndef UART_RX_MAJORITY_VOTE_EN
    if (glitch) r = '1;
`endif
    return r;
  endfunction

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] b, input bit stop_ok,
                            input bit present, input bit glitch);
    int d, p;
    d = (div < 16'd3) ? 3 : int'(div);
    p = d + 1;
    if (present) begin
      exp_q.push_back(model_byte(b, glitch));
      // Sync stages, start entry, half bit, data bits, stop bits, emit register.
      exp_t_q.push_back(cyc + 2 + 1 + (d >> 1) + 1 + W * p + p * (1 + int'(nstop)) + 1);
    end
    if (!stop_ok) fe_exp++;
    hold(1'b0, p);
    for (int i = 0; i < W; i++) begin
      if (glitch) begin
        hold(b[i], p / 2);
        hold(1'b1, 1);
        hold(b[i], p - p / 2 - 1);
      end else begin
        hold(b[i], p);
      end
    end
    if (stop_ok) hold(1'b1, p * (1 + int'(nstop)));
    else         hold(1'b0, p);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin : mon
    logic [W-1:0] e;
    int t;
    if (reset) begin
      if (rx_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h want none", rx_data);
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check("rx_data", rx_data, e);
          total++;
          if (cyc < t - 1 || cyc > t + 1) begin
            bad++;
            $display("FAIL latency: got cycle %0d want %0d", cyc, t);
          end
        end
      end
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
    end
    prev_valid = rx_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", state_db, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    reset = 1'b1;
    rxen  = 1'b1;
    hold(1'b1, 5);

    // Single byte, one stop bit.
    div = 16'd9; nstop = 1'b0; rx_ready = 1'b1;
    send_frame(8'hA5, 1, 1, 0);
    hold(1'b1, 20);

    // Two stop bits, consumer stalled: second byte overruns.
    nstop = 1'b1; rx_ready = 1'b0;
    send_frame(8'h3C, 1, 1, 0);
    send_frame(8'hC3, 1, 0, 0);
    ov_exp++;
    hold(1'b1, 10);
    check("held_valid", rx_valid, 1);
    check("held_data", rx_data, 8'h3C);
    check("overrun_count", ov_seen, ov_exp);
    rx_ready = 1'b1;
    hold(1'b1, 1);
    check("consumed_valid", rx_valid, 0);
    nstop = 1'b0;
    hold(1'b1, 5);

    // Stop bit low, then a held-low line.
    send_frame(8'h55, 0, 0, 0);
    hold(1'b0, 30);
    check("break_state", state_db, 5);
    check("ferr_count", fe_seen, fe_exp);
    hold(1'b1, 5);
    check("break_exit", state_db, 0);
    send_frame(8'h0F, 1, 1, 0);
    hold(1'b1, 15);

    // Short low pulse is rejected as a false start.
    div = 16'd15;
    hold(1'b0, 3);
    check("glitch_start", state_db, 1);
    hold(1'b1, 12);
    check("glitch_idle", state_db, 0);
    check("glitch_busy", busy, 0);

    // rxen dropped mid-frame.
    div = 16'd9;
    hold(1'b0, 10);
    for (int i = 0; i < 4; i++) hold(1'b1, 10);
    hold(1'b1, 3);
    rxen = 1'b0;
    hold(1'b1, 1);
    check("rxen_idle", state_db, 0);
    hold(1'b1, 60);
    rxen = 1'b1;
    hold(1'b1, 5);

    // Asynchronous reset in the middle of a frame.
    hold(1'b0, 10);
    hold(1'b0, 20);
    check("midframe_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("areset_state", state_db, 0);
    check("areset_data", rx_data, 0);
    check("areset_valid", rx_valid, 0);
    check("areset_busy", busy, 0);
    rxd = 1'b1;
    @(posedge clock);
    #1;
    hold(1'b1, 3);
    reset = 1'b1;
    hold(1'b1, 5);

    // Mid-bit glitches on an all-zero byte.
    send_frame(8'h00, 1, 1, 1);
    hold(1'b1, 20);

    // Randomised frames with assorted divisors, including the clamped ones.
    for (int n = 0; n < 16; n++) begin
      div   = 16'($urandom_range(0, 12));
      nstop = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)), 1, 1, 0);
      hold(1'b1, $urandom_range(3, 15));
    end
    hold(1'b1, 30);

    check("pending_bytes", exp_q.size(), 0);
    check("final_ferr", fe_seen, fe_exp);
    check("final_ovr", ov_seen, ov_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side serial PHY for the peripheral UART. Sits directly upstream of the RX FIFO.
- Synchronises the asynchronous rxd pin, detects and validates start bits, and samples 8 data bits LSB-first at mid-bit.
- Checks 1 or 2 stop bits and presents each byte on a valid/ready handshake for the FIFO write port.
- Bit timing comes from the UART divisor register.

Parameters:
DATA_BITS  8  bits per frame, LSB first
SYNC_STAGES  2  flops in the rxd synchroniser (minimum 2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
rxd  in  1  serial line, idle high, asynchronous to clock
div  in  16  bit period = div+1 clock cycles; values below 3 treated as 3
rxen  in  1  receiver enable
nstop  in  1  0: one stop bit, 1: two stop bits
rx_data  out  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  out  1  byte available
rx_ready  in  1  consumer accepts byte when rx_valid&rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun  out  1  one-cycle pulse: byte completed while rx_valid still 1
busy  out  1  FSM not in Idle
state_db  out  3  debug, encoded FSM state

Behaviour:
- **Reset (reset=0, async):**
  - State = Idle; rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops and the shift register reset to 1s.
  - Bit counter and bit index reset to 0.
  - Reset mid-frame discards the frame.
- **Synchroniser:** rx_s is rxd after SYNC_STAGES flops. All decisions use rx_s, or the vote result (see Optional Feature).
- **Bit counter:** 16-bit counter cnt. Cleared on every state entry; increments each cycle. The effective divisor is D = max(div,3).
- **States and transitions:**
  - Idle (0): if rxen & rx_s=0 -> Start.
  - Start (1): at cnt=D>>1, sample.
    - Sample 0 -> Data, bit index=0.
    - Sample 1 (glitch) -> Idle; no output, no error.
  - Data (2): at cnt=D, sample into shift register MSB side, shifting right (LSB first).
    - The last bit (index DATA_BITS-1) -> Stop1.
  - Stop1 (3): at cnt=D, sample.
    - Sample 0 -> frame_err pulse, byte dropped -> Break.
    - Sample 1 & nstop=1 -> Stop2.
    - Sample 1 & nstop=0 -> emit byte, go to Idle.
  - Stop2 (4): at cnt=D.
    - Sample 1 -> emit, go to Idle.
    - Sample 0 -> frame_err pulse, go to Break.
  - Break (5): wait for rx_s=1 -> Idle. This prevents a held-low line from producing repeated frames.
- **rxen behaviour:**
  - rxen=0 in any state forces Idle on the next edge.
  - The partial frame is discarded with no error.
  - rx_valid and rx_data are unaffected.
- **Emit (registered, 1 cycle after the accepting stop sample):**
  - If rx_valid=0: rx_data <= shift register, rx_valid <= 1.
  - If rx_valid=1: overrun pulses; the old byte is kept and the new byte is dropped.
  - If rx_ready=1 on the same edge as an emit while rx_valid=1: the old byte is consumed, the new byte loads, rx_valid stays 1, and there is no overrun.
- **Handshake:**
  - rx_valid deasserts on the edge where rx_valid&rx_ready=1, with no new emit.
  - rx_data is held otherwise.
- **Latency:** rx_valid rises exactly SYNC_STAGES + 1 + (D>>1) + 1 + DATA_BITS·(D+1) + (D+1)·(1+nstop) + 1 cycles after the rxd falling edge at the pin, ±1 for synchroniser metastability alignment.
- **Divisor changes:** div is sampled continuously. Changing it mid-frame is permitted but the timing of that frame is undefined; the FSM must still return to Idle or Break.
- **busy:** busy=1 in every state except Idle.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- **Defined:**
  - A 3-bit history of rx_s is kept.
  - Every sample point uses the majority of the last three rx_s values, covering cycles cnt-2..cnt.
  - A single-cycle glitch at the sample point is rejected.
  - The Idle start detect still uses raw rx_s.
- **Undefined:** every sample point uses rx_s directly, and the history register is not instantiated.
- Port list, latency and state encoding are identical in both builds.

Test Plan:
- div=9, nstop=0, rxen=1, send 0xA5 (10 cycles/bit), rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, no frame_err/overrun.
- div=9, nstop=1, send 0x3C then 0xC3 back-to-back, rx_ready=0 -> first byte 0x3C held; overrun pulse at second emit; raise rx_ready -> 0x3C consumed, rx_valid=0.
- div=9, send 0x55 with stop bit forced 0, then line held low 30 cycles -> frame_err one pulse, no rx_valid, state Break until rxd=1, then a following 0x0F is received correctly.
- div=15, 3-cycle low pulse on idle rxd -> Start entered, sample at cnt=7 is 1, return to Idle; no output, no error.
- Send 0xFF, deassert rxen during bit 4 -> Idle next cycle, no output; then reset=0 asynchronously mid-frame of a second byte -> all outputs 0 immediately.
- With UART_RX_MAJORITY_VOTE_EN, div=9, send 0x00 with 1-cycle high glitch at each data mid-bit -> rx_data=0x00. Without the macro, the same stimulus -> rx_data=0xFF.
